// File: rtl/note_src_arbiter.sv
// Two-source round-robin arbiter for a shared 4-bit note/digit bus.
// Owns the downstream 2:1 mux select and republishes the owner's data one
// cycle after the grant, with a minimum-hold counter for fair time-slicing.
module note_src_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] data0,
    input  logic [3:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       sel,
    output logic [3:0] out,
    output logic       out_valid
);

    localparam int unsigned DATA_W = 4;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_hold_cnt;
    logic [CNT_W-1:0]    w_hold_nxt;
    logic                r_last_grant;
    logic                w_last_nxt;
    logic                w_hold_done;
    logic                r_gnt0;
    logic                r_gnt1;
    logic                r_sel;
    logic                w_sel_nxt;
    logic [DATA_W-1:0]   r_out;
    logic [DATA_W-1:0]   w_out_nxt;
    logic                r_out_valid;

    // Owner has served its minimum slice and may be pre-empted
    assign w_hold_done = (r_hold_cnt >= HOLD_MAX);

    // State register plus arbitration bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_hold_cnt   <= '0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_next;
            r_hold_cnt   <= w_hold_nxt;
            r_last_grant <= w_last_nxt;
        end
    end

    // Next-state: tie-break away from last owner, early release, hold-based pre-emption
    always_comb begin
        w_next     = r_state;
        w_hold_nxt = r_hold_cnt;
        w_last_nxt = r_last_grant;

        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    w_next = r_last_grant ? ST_OWN0 : ST_OWN1;
                end else if (req0) begin
                    w_next = ST_OWN0;
                end else if (req1) begin
                    w_next = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!req0) begin
                    w_next = req1 ? ST_OWN1 : ST_IDLE;
                end else if (w_hold_done && req1) begin
                    w_next = ST_OWN1;
                end else if (!w_hold_done) begin
                    w_hold_nxt = r_hold_cnt + CNT_W'(1);
                end
            end
            ST_OWN1: begin
                if (!req1) begin
                    w_next = req0 ? ST_OWN0 : ST_IDLE;
                end else if (w_hold_done && req0) begin
                    w_next = ST_OWN0;
                end else if (!w_hold_done) begin
                    w_hold_nxt = r_hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase

        // Any fresh ownership restarts the slice and records the winner
        if ((w_next != r_state) && (w_next != ST_IDLE)) begin
            w_hold_nxt = '0;
            w_last_nxt = (w_next == ST_OWN1);
        end
    end

    // Select follows the owner; held through IDLE so the mux output stays put
    always_comb begin
        w_sel_nxt = r_sel;
        if (w_next == ST_OWN1) begin
            w_sel_nxt = 1'b1;
        end else if (w_next == ST_OWN0) begin
            w_sel_nxt = 1'b0;
        end
    end

    // Data capture from the current (pre-edge) owner; IDLE keeps last value
    always_comb begin
        w_out_nxt = r_out;
        case (r_state)
            ST_OWN0: w_out_nxt = data0;
            ST_OWN1: w_out_nxt = data1;
            default: w_out_nxt = r_out;
        endcase
    end

    // Registered grants, select and published data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_sel       <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_gnt0      <= (w_next == ST_OWN0);
            r_gnt1      <= (w_next == ST_OWN1);
            r_sel       <= w_sel_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= (r_state != ST_IDLE);
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign sel       = r_sel;
    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_note_src_arbiter.sv
// Self-checking bench for note_src_arbiter: directed scenarios with literal
// expectations plus a cycle-level reference model compared on every falling edge.
module tb_note_src_arbiter;

    localparam int unsigned HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic       req1;
    logic [3:0] data0;
    logic [3:0] data1;
    logic       gnt0;
    logic       gnt1;
    logic       sel;
    logic [3:0] out;
    logic       out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    note_src_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: owner is 0/1 or 2 for nobody; tenure counts cycles owned
    int         m_own;
    int         m_ten;
    int         m_last;
    logic       m_sel;
    logic [3:0] m_out;
    logic       m_val;

    always @(posedge clk or negedge rst_n) begin : model
        int   nxt;
        int   ten;
        logic rq [2];
        if (!rst_n) begin
            m_own  <= 2;
            m_ten  <= 0;
            m_last <= 1;
            m_sel  <= 1'b0;
            m_out  <= 4'h0;
            m_val  <= 1'b0;
        end else begin
            rq[0] = req0;
            rq[1] = req1;
            nxt   = m_own;
            ten   = m_ten;
            if (m_own == 2) begin
                if (rq[0] && rq[1]) nxt = 1 - m_last;
                else if (rq[0])     nxt = 0;
                else if (rq[1])     nxt = 1;
            end else if (!rq[m_own]) begin
                nxt = rq[1 - m_own] ? 1 - m_own : 2;
            end else if (rq[1 - m_own] && m_ten >= int'(HOLD)) begin
                nxt = 1 - m_own;
            end else begin
                ten = m_ten + 1;
            end
            if (nxt != m_own && nxt != 2) begin
                ten = 1;
                m_last <= nxt;
            end
            m_val <= (m_own != 2);
            if (m_own == 0) m_out <= data0;
            if (m_own == 1) m_out <= data1;
            if (nxt == 0) m_sel <= 1'b0;
            if (nxt == 1) m_sel <= 1'b1;
            m_own <= nxt;
            m_ten <= ten;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_gnt0", 8'(gnt0), 8'(m_own == 0));
            chk("cyc_gnt1", 8'(gnt1), 8'(m_own == 1));
            chk("cyc_sel", 8'(sel), 8'(m_sel));
            chk("cyc_out", 8'(out), 8'(m_out));
            chk("cyc_valid", 8'(out_valid), 8'(m_val));
            chk("cyc_excl", 8'(gnt0 & gnt1), 8'h0);
        end
    end

    // Apply inputs, then land 2 time units after the next rising edge
    task automatic step(input logic r0, input logic r1, input logic [3:0] d0, input logic [3:0] d1);
        req0  = r0;
        req1  = r1;
        data0 = d0;
        data1 = d1;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, "_gnt0"}, 8'(gnt0), 8'h0);
        chk({nm, "_gnt1"}, 8'(gnt1), 8'h0);
        chk({nm, "_sel"}, 8'(sel), 8'h0);
        chk({nm, "_out"}, 8'(out), 8'h0);
        chk({nm, "_valid"}, 8'(out_valid), 8'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; data0 = 4'h0; data1 = 4'h0;

        // 1. Reset held with random activity on the inputs
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
            chk_cleared("rst_hold");
        end
        rst_n = 1'b1;
        step(1'b0, 1'b0, 4'h0, 4'h0);

        // 2. Single source
        step(1'b1, 1'b0, 4'hA, 4'h0);
        chk("single_gnt0_rise", 8'(gnt0), 8'h1);
        chk("single_valid_lag", 8'(out_valid), 8'h0);
        step(1'b1, 1'b0, 4'hA, 4'h0);
        chk("single_out_A", 8'(out), 8'hA);
        chk("single_valid", 8'(out_valid), 8'h1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'hA, 4'h0);
        step(1'b0, 1'b0, 4'hA, 4'h0);
        chk("single_gnt0_fall", 8'(gnt0), 8'h0);
        chk("single_valid_tail", 8'(out_valid), 8'h1);
        step(1'b0, 1'b0, 4'h0, 4'h0);
        chk("single_valid_fall", 8'(out_valid), 8'h0);
        chk("single_out_hold", 8'(out), 8'hA);
        chk("single_sel_hold", 8'(sel), 8'h0);

        // 3. Continuous tie from reset: 4-cycle alternating slices
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 4'h2, 4'h9);
            chk("tie_gnt0", 8'(gnt0), 8'(((i / 4) % 2) == 0));
            chk("tie_gnt1", 8'(gnt1), 8'(((i / 4) % 2) == 1));
            chk("tie_sel", 8'(sel), 8'(((i / 4) % 2) == 1));
            if (i > 0) chk("tie_no_gap", 8'(out_valid), 8'h1);
        end
        step(1'b0, 1'b0, 4'h0, 4'h0);

        // 4. Early release hands straight over to the waiting source
        step(1'b1, 1'b0, 4'h0, 4'h5);
        chk("hand_gnt0", 8'(gnt0), 8'h1);
        step(1'b1, 1'b1, 4'h0, 4'h5);
        step(1'b1, 1'b1, 4'h0, 4'h5);
        chk("hand_still0", 8'(gnt0), 8'h1);
        step(1'b0, 1'b1, 4'h0, 4'h5);
        chk("hand_gnt1", 8'(gnt1), 8'h1);
        chk("hand_gnt0_off", 8'(gnt0), 8'h0);
        chk("hand_sel", 8'(sel), 8'h1);
        step(1'b0, 1'b1, 4'h0, 4'h5);
        chk("hand_out5", 8'(out), 8'h5);
        chk("hand_valid", 8'(out_valid), 8'h1);

        // 5. Owner data tracking, non-owner data ignored
        step(1'b0, 1'b1, 4'h1, 4'h3);
        chk("track_3", 8'(out), 8'h3);
        step(1'b0, 1'b1, 4'h2, 4'h7);
        chk("track_7", 8'(out), 8'h7);
        step(1'b0, 1'b1, 4'hC, 4'hF);
        chk("track_F", 8'(out), 8'hF);
        step(1'b0, 1'b1, 4'h9, 4'hF);
        chk("track_ignore_d0", 8'(out), 8'hF);

        // 6. Asynchronous reset during OWN1 at hold count 2
        step(1'b0, 1'b0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'h6);
        step(1'b0, 1'b1, 4'h0, 4'h6);
        step(1'b0, 1'b1, 4'h0, 4'h6);
        chk("mid_gnt1_pre", 8'(gnt1), 8'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cleared("mid_async");
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b1, 4'h4, 4'h6);
        chk("mid_first_gnt0", 8'(gnt0), 8'h1);
        chk("mid_first_gnt1", 8'(gnt1), 8'h0);
        step(1'b1, 1'b1, 4'h4, 4'h6);
        chk("mid_out4", 8'(out), 8'h4);

        // Random traffic, checked by the per-cycle model comparison
        for (int i = 0; i < 120; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 4'($urandom), 4'($urandom));
        end
        step(1'b0, 1'b0, 4'h0, 4'h0);
        step(1'b0, 1'b0, 4'h0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
